// File: rtl/queuenm_retire.sv
// queuenm_retire: drain/wakeup stage for the queuenm buffer.
// Broadcasts wakeups, pops ready heads into a 2-entry output buffer.
module queuenm_retire #(
   parameter int M_WIDTH   = 16,
   parameter int N_WIDTH   = 16,
   parameter int Q_LENGTH  = 16,
   parameter int TIMEOUT   = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         q_empty,
   input  logic [M_WIDTH+N_WIDTH-1:0]   q_dout,
   input  logic [M_WIDTH*Q_LENGTH-1:0]  q_old_m_vector,
   output logic                         q_rd,
   output logic [Q_LENGTH-1:0]          q_modify_vector,
   output logic [M_WIDTH*Q_LENGTH-1:0]  q_new_m_vector,
   input  logic [M_WIDTH-1:0]           wake_mask,
   input  logic                         flush,
   output logic                         out_valid,
   output logic [N_WIDTH-1:0]           out_data,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [CNT_WIDTH-1:0]         retired_cnt,
   output logic                         stall_err
);

   localparam int SW = $clog2(TIMEOUT);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [N_WIDTH-1:0]   buf0_q, buf0_d;
   logic [N_WIDTH-1:0]   buf1_q, buf1_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [1:0]           cnt_mid;
   logic [CNT_WIDTH-1:0] ret_q, ret_d;
   logic [SW-1:0]        stall_q, stall_d;
   logic                 err_q, err_d;

   logic [M_WIDTH-1:0]   head_m;
   logic [N_WIDTH-1:0]   head_n;
   logic                 elig;
   logic                 drain;

   assign head_m = q_dout[M_WIDTH+N_WIDTH-1:N_WIDTH];
   assign head_n = q_dout[N_WIDTH-1:0];
   assign elig   = !q_empty && ((head_m & ~wake_mask) == '0);

   assign q_modify_vector = (wake_mask != '0) ? '1 : '0;

   always_comb begin
      q_new_m_vector = '0;
      for (int i = 0; i < Q_LENGTH; i++) begin
         q_new_m_vector[i*M_WIDTH +: M_WIDTH] =
            q_old_m_vector[i*M_WIDTH +: M_WIDTH] & ~wake_mask;
      end
   end

   assign out_valid   = (cnt_q != 2'd0);
   assign out_data    = out_valid ? buf0_q : '0;
   assign busy        = (state_q == FLUSH) || out_valid || !q_empty;
   assign retired_cnt = ret_q;
   assign stall_err   = err_q;

   assign drain = (state_q == RUN) && !flush && out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      cnt_d   = cnt_q;
      cnt_mid = cnt_q;
      ret_d   = ret_q;
      stall_d = stall_q;
      err_d   = err_q;
      q_rd    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (flush) begin
               cnt_d   = 2'd0;
               state_d = FLUSH;
            end else begin
               q_rd = !clr && elig && (cnt_q != 2'd2);
               // Drain shifts the buffer first; the push lands at the new tail.
               if (drain) begin
                  buf0_d  = buf1_q;
                  cnt_mid = cnt_q - 2'd1;
               end
               if (q_rd) begin
                  if (cnt_mid == 2'd0) buf0_d = head_n;
                  else                 buf1_d = head_n;
                  cnt_d = cnt_mid + 2'd1;
                  ret_d = ret_q + CNT_WIDTH'(1);
               end else begin
                  cnt_d = cnt_mid;
               end
            end
            if (!q_empty && !q_rd) begin
               if (stall_q == SW'(TIMEOUT - 1)) err_d = 1'b1;
               else                             stall_d = stall_q + SW'(1);
            end else begin
               stall_d = '0;
            end
         end
         FLUSH: begin
            q_rd    = !clr && !q_empty;
            stall_d = '0;
            if (q_empty) state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= RUN;
         buf0_q  <= '0;
         buf1_q  <= '0;
         cnt_q   <= 2'd0;
         ret_q   <= '0;
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

endmodule
